l1_sram_arbiter: RTL and testbench
==================================

L1_SRAM_ARBITER -- requirements
Module: l1_sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, line index width (256 lines) SHALL apply.
REQ-002 Parameter DATA_WIDTH, default 1024, line width in bits SHALL apply.
REQ-003 Parameter NUM_WMASKS, default 128, byte-lane write-mask width SHALL apply.
REQ-004 Parameter STARVE_LIMIT, default 4, maximum consecutive cycles a store may lose arbitration SHALL apply.
REQ-005 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic on posedge; SRAM clk0/clk1 driven from this clock externally
  rst  in  1  synchronous, active-high reset
  refill_valid/refill_ready  in/out  1/1  line-refill write handshake
  refill_addr/refill_data  in  ADDR_WIDTH/DATA_WIDTH  refill line index and full line
  st_valid/st_ready  in/out  1/1  byte-masked store handshake
  st_addr/st_wmask/st_data  in  ADDR_WIDTH/NUM_WMASKS/DATA_WIDTH  store index, lanes, data
  rd_valid/rd_ready  in/out  1/1  line-read request handshake
  rd_addr  in  ADDR_WIDTH  read line index
  rd_rvalid/rd_rdata  out  1/DATA_WIDTH  read response
  init_done  out  1  high once reset sweep complete
  sram_csb0/sram_addr0/sram_wmask0/sram_din0  out  1/ADDR_WIDTH/NUM_WMASKS/DATA_WIDTH  SRAM write port, csb active-low
  sram_csb1/sram_addr1  out  1/ADDR_WIDTH  SRAM read port, csb active-low
  sram_dout1  in  DATA_WIDTH  SRAM read data

Function
REQ-006 Top FSM SHALL have states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-007 In INIT the block SHALL write line = counter, sram_wmask0 all ones, sram_din0 zero, one line per cycle; all *_ready and rd_rvalid low.
REQ-008 After writing line 2^ADDR_WIDTH-1 (256 cycles) the FSM SHALL enter RUN and assert init_done from the following cycle, held until rst.
REQ-009 In RUN, a handshake SHALL complete when valid and ready are both high on a posedge; ready is combinational from the valid inputs and internal state.
REQ-010 Write port SHALL grant at most one of refill/store per cycle; refill wins by default.
REQ-011 A 3-bit starve counter SHALL increment each cycle st_valid is high and not granted, clear on store grant or st_valid low; when counter equals STARVE_LIMIT, store SHALL win over refill.
REQ-012 Granted write SHALL drive sram_csb0=0 with its address, data and mask (refill mask all ones) in the same cycle; idle cycles drive sram_csb0=1, mask zero.
REQ-013 Read accept SHALL drive sram_csb1=0, sram_addr1=rd_addr in the same cycle; rd_rvalid SHALL assert exactly one cycle later with rd_rdata sampled from sram_dout1; throughput one read per cycle.
REQ-014 Collision: if rd_valid and a granted write target the same address in the same cycle, rd_ready SHALL be low that cycle (read retried next cycle), except as allowed by REQ-019.
REQ-015 Read and write to different addresses in the same cycle SHALL both proceed.
REQ-016 rd_rdata SHALL hold its last value when rd_rvalid is low.

Reset
REQ-017 On rst: sram_csb0=1, sram_csb1=1, all *_ready=0, rd_rvalid=0, init_done=0, starve counter=0, rd_rdata=0; any in-flight read response SHALL be dropped.
REQ-018 rst asserted mid-INIT or mid-RUN SHALL restart the sweep at line 0 on the cycle after rst deasserts.

Configuration
REQ-019 Macro L1_SRAM_ARB_BYPASS_EN: when defined, a same-address collision with a granted refill SHALL accept the read (no stall), keep sram_csb1=1, and return refill_data on rd_rvalid one cycle later; store collisions still stall. When undefined, all collisions stall per REQ-014.

Verification
REQ-020 rst 1 cycle then release -> sram_csb0 low 256 consecutive cycles, addr 0..255, din 0; init_done high on cycle 257; no ready asserted before.
REQ-021 RUN: refill addr 0x10 and store addr 0x20 valid continuously -> refill granted 4 cycles, store granted 5th cycle, counter cleared.
REQ-022 Store addr 0x05 wmask 0x...0001 data 0xAB, next cycle read 0x05 -> rd_rvalid one cycle after accept, rd_rdata byte0 0xAB, other bytes 0.
REQ-023 Refill addr 0x33 plus read 0x33 same cycle -> without macro rd_ready low, read accepted next cycle; with L1_SRAM_ARB_BYPASS_EN rd_ready high, sram_csb1=1, rd_rdata = refill_data.
REQ-024 rst asserted while read pending in RUN -> rd_rvalid stays 0, sweep restarts at line 0.
REQ-025 Back-to-back reads 0x01,0x02,0x03 -> rd_rvalid high three consecutive cycles, data in order.

Source files
------------

// File: rtl/l1_sram_arbiter.sv
// l1_sram_arbiter: arbitrates refill/store writes and line reads onto a 1W/1R SRAM, zeroing it after reset
//
// Ports
//   clk, rst                               single clock, synchronous active-high reset
//   refill_valid/ready, refill_addr/data   full-line refill writes (preferred writer)
//   st_valid/ready, st_addr/wmask/data     byte-masked stores (anti-starvation priority)
//   rd_valid/ready, rd_addr                line read requests
//   rd_rvalid, rd_rdata                    read response, one cycle after accept
//   init_done                              high once the zeroing sweep has finished
//   sram_csb0/addr0/wmask0/din0            SRAM write port (csb active-low)
//   sram_csb1/addr1, sram_dout1            SRAM read port (csb active-low)
//
// Build option
//   L1_SRAM_ARB_BYPASS_EN  a read colliding with a granted refill is accepted and served
//                          from refill_data instead of stalling
module l1_sram_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 1024,
    parameter int NUM_WMASKS   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refill_valid,
    output logic                  refill_ready,
    input  logic [ADDR_WIDTH-1:0] refill_addr,
    input  logic [DATA_WIDTH-1:0] refill_data,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [NUM_WMASKS-1:0] st_wmask,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    typedef enum logic {INIT, RUN} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic [2:0]            starve_q, starve_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  init_wr, run, st_prio, ref_win, st_win, wr_en, addr_hit, rd_acc, byp;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] resp_data;
`ifdef L1_SRAM_ARB_BYPASS_EN
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
`endif
    // rst gates every output combinationally so the port is quiet during the reset cycle itself
    always_comb begin
        init_wr  = state_q == INIT && !rst;
        run      = state_q == RUN && !rst;
        st_prio  = st_valid && starve_q == 3'(STARVE_LIMIT);
        ref_win  = run && refill_valid && !st_prio;
        st_win   = run && st_valid && !ref_win;
        wr_en    = ref_win || st_win;
        wr_addr  = ref_win ? refill_addr : st_addr;
        addr_hit = wr_en && wr_addr == rd_addr;
`ifdef L1_SRAM_ARB_BYPASS_EN
        byp       = addr_hit && ref_win && rd_valid;
        rd_ready  = run && (!addr_hit || ref_win);
        resp_data = byp_q ? byp_data_q : sram_dout1;
`else
        byp       = 1'b0;
        rd_ready  = run && !addr_hit;
        resp_data = sram_dout1;
`endif
        rd_acc       = rd_valid && rd_ready;
        refill_ready = ref_win;
        st_ready     = st_win;
        init_done    = run;
        sram_csb0    = !(init_wr || wr_en);
        sram_addr0   = init_wr ? sweep_q : wr_addr;
        sram_wmask0  = (init_wr || ref_win) ? '1 : st_win ? st_wmask : '0;
        sram_din0    = init_wr ? '0 : ref_win ? refill_data : st_win ? st_data : '0;
        // a bypassed read never touches the SRAM array
        sram_csb1    = !(rd_acc && !byp);
        sram_addr1   = rd_addr;
        rd_rvalid    = rvalid_q && !rst;
        rd_rdata     = rst ? '0 : rvalid_q ? resp_data : rdata_q;
    end
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + ADDR_WIDTH'(1);
            state_d = sweep_q == '1 ? RUN : INIT;
        end
        starve_d = (state_q == RUN && st_valid && !st_win) ? starve_q + 3'd1 : 3'd0;
        rvalid_d = rd_acc;
        rdata_d  = rvalid_q ? resp_data : rdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            sweep_q  <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end
`ifdef L1_SRAM_ARB_BYPASS_EN
    always_ff @(posedge clk) begin
        byp_q      <= rst ? 1'b0 : byp;
        byp_data_q <= refill_data;
    end
`endif
endmodule

// File: tb/tb_l1_sram_arbiter.sv
// tb_l1_sram_arbiter: directed and randomized checks of l1_sram_arbiter against a line-level model
module tb_l1_sram_arbiter;
    localparam int AW = 8, DW = 1024, NW = 128, SL = 4, LINES = 256;
    logic clk = 1'b0;
    logic rst;
    logic refill_valid, refill_ready;
    logic [AW-1:0] refill_addr;
    logic [DW-1:0] refill_data;
    logic st_valid, st_ready;
    logic [AW-1:0] st_addr;
    logic [NW-1:0] st_wmask;
    logic [DW-1:0] st_data;
    logic rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic init_done;
    logic sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [NW-1:0] sram_wmask0;
    logic [DW-1:0] sram_din0;
    logic sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sram_mem [LINES];
    logic [DW-1:0] mem_m [LINES];
    int starve_m;
    bit pend_m;
    logic [DW-1:0] pend_d_m, last_m;
    bit e_ref, e_st, e_rd, e_byp;

    always #5 clk = ~clk;

    l1_sram_arbiter dut (
        .clk(clk), .rst(rst),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_addr(refill_addr), .refill_data(refill_data),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_wmask(st_wmask), .st_data(st_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0),
        .sram_wmask0(sram_wmask0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // synchronous 1W/1R SRAM macro: byte-masked write, registered read data
    always @(posedge clk) begin
        if (!sram_csb0)
            for (int b = 0; b < NW; b++)
                if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
        if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        refill_valid = 1'b0;
        st_valid     = 1'b0;
        rd_valid     = 1'b0;
    endtask

    task automatic rand_line(output logic [DW-1:0] v);
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_mask(output logic [NW-1:0] v);
        for (int i = 0; i < NW / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    // after the sweep every line reads as zero and no response is outstanding
    task automatic model_reset();
        for (int i = 0; i < LINES; i++) mem_m[i] = '0;
        starve_m = 0;
        pend_m   = 1'b0;
        pend_d_m = '0;
        last_m   = '0;
    endtask

    // who should win this cycle, from the arbitration rules and current inputs
    task automatic model_eval();
        bit prio, hit;
        logic [AW-1:0] wa;
        prio  = st_valid && starve_m == SL;
        e_ref = refill_valid && !prio;
        e_st  = st_valid && !e_ref;
        wa    = e_ref ? refill_addr : st_addr;
        hit   = (e_ref || e_st) && wa == rd_addr;
`ifdef L1_SRAM_ARB_BYPASS_EN
        e_byp = hit && e_ref && rd_valid;
        e_rd  = rd_valid && (!hit || e_ref);
`else
        e_byp = 1'b0;
        e_rd  = rd_valid && !hit;
`endif
    endtask

    task automatic model_commit();
        logic [DW-1:0] nd, line;
        nd = e_byp ? refill_data : mem_m[rd_addr];
        if (pend_m) last_m = pend_d_m;
        pend_m = e_rd;
        if (e_rd) pend_d_m = nd;
        if (e_ref) mem_m[refill_addr] = refill_data;
        else if (e_st) begin
            line = mem_m[st_addr];
            for (int b = 0; b < NW; b++)
                if (st_wmask[b]) line[b*8 +: 8] = st_data[b*8 +: 8];
            mem_m[st_addr] = line;
        end
        starve_m = (st_valid && !e_st) ? starve_m + 1 : 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        refill_valid = 1'b1; refill_addr = 8'h01; refill_data = '1;
        st_valid = 1'b1; st_addr = 8'h02; st_wmask = '1; st_data = '1;
        rd_valid = 1'b1; rd_addr = 8'h03;
        next();
        @(negedge clk);
        checks++;
        if ({sram_csb0, sram_csb1} !== 2'b11) begin
            failures++;
            $display("FAIL reset_csb got=%b exp=11", {sram_csb0, sram_csb1});
        end
        checks++;
        if ({refill_ready, st_ready, rd_ready, rd_rvalid, init_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {refill_ready, st_ready, rd_ready, rd_rvalid, init_done});
        end
        checks++;
        if (rd_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", rd_rdata[63:0]);
        end
        next();
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [AW+7:0] act, exp;
        for (int i = 0; i < LINES; i++) begin
            @(negedge clk);
            act = {sram_csb0, sram_addr0, sram_din0 === '0, &sram_wmask0,
                   refill_ready, st_ready, rd_ready, rd_rvalid, init_done};
            exp = {1'b0, AW'(i), 1'b1, 1'b1, 5'b0};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL init_line%0d got=%h exp=%h", i, act, exp);
            end
            next();
        end
        drive_idle();
        model_reset();
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || sram_csb0 !== 1'b1) begin
            failures++;
            $display("FAIL init_done got=%b csb0=%b exp=1 1", init_done, sram_csb0);
        end
        model_eval();
        model_commit();
        next();
    endtask

    task automatic test_starve();
        refill_valid = 1'b1; refill_addr = 8'h10; rand_line(refill_data);
        st_valid = 1'b1; st_addr = 8'h20; rand_mask(st_wmask); rand_line(st_data);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if ({refill_ready, st_ready} !== ((c == 4) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL starve_c%0d got=%b exp=%b", c, {refill_ready, st_ready}, (c == 4) ? 2'b01 : 2'b10);
            end
            model_commit();
            next();
        end
        drive_idle();
        @(negedge clk);
        model_eval();
        model_commit();
        next();
    endtask

    task automatic test_store_read();
        drive_idle();
        st_valid = 1'b1; st_addr = 8'h05; st_wmask = NW'(1); st_data = DW'(8'hAB);
        @(negedge clk);
        model_eval();
        checks++;
        if ({st_ready, sram_csb0, sram_addr0, sram_wmask0 === NW'(1), sram_din0 === DW'(8'hAB)} !== {2'b10, 8'h05, 2'b11}) begin
            failures++;
            $display("FAIL store_write got rdy=%b csb0=%b a=%h", st_ready, sram_csb0, sram_addr0);
        end
        model_commit();
        next();
        drive_idle();
        rd_valid = 1'b1; rd_addr = 8'h05;
        @(negedge clk);
        model_eval();
        checks++;
        if ({rd_ready, sram_csb1, sram_addr1} !== {2'b10, 8'h05}) begin
            failures++;
            $display("FAIL store_rd_acc got rdy=%b csb1=%b a=%h exp 1 0 05", rd_ready, sram_csb1, sram_addr1);
        end
        model_commit();
        next();
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (rd_rvalid !== (c == 0) || rd_rdata !== DW'(8'hAB)) begin
                failures++;
                $display("FAIL store_rd_resp%0d got v=%b d=%h exp v=%b d=ab", c, rd_rvalid, rd_rdata[63:0], c == 0);
            end
            model_commit();
            next();
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] r;
        rand_line(r);
        drive_idle();
        refill_valid = 1'b1; refill_addr = 8'h33; refill_data = r;
        rd_valid = 1'b1; rd_addr = 8'h33;
        @(negedge clk);
        model_eval();
        checks++;
`ifdef L1_SRAM_ARB_BYPASS_EN
        if ({refill_ready, rd_ready, sram_csb1} !== 3'b111) begin
            failures++;
            $display("FAIL coll_bypass got=%b exp=111", {refill_ready, rd_ready, sram_csb1});
        end
        model_commit();
        next();
        drive_idle();
`else
        if ({refill_ready, rd_ready, sram_csb1} !== 3'b101) begin
            failures++;
            $display("FAIL coll_stall got=%b exp=101", {refill_ready, rd_ready, sram_csb1});
        end
        model_commit();
        next();
        refill_valid = 1'b0;
        @(negedge clk);
        model_eval();
        checks++;
        if ({rd_ready, sram_csb1, sram_addr1} !== {2'b10, 8'h33}) begin
            failures++;
            $display("FAIL coll_retry got rdy=%b csb1=%b a=%h exp 1 0 33", rd_ready, sram_csb1, sram_addr1);
        end
        model_commit();
        next();
        drive_idle();
`endif
        @(negedge clk);
        model_eval();
        checks++;
        if (rd_rvalid !== 1'b1 || rd_rdata !== r) begin
            failures++;
            $display("FAIL coll_data got v=%b d=%h exp v=1 d=%h", rd_rvalid, rd_rdata[127:0], r[127:0]);
        end
        model_commit();
        next();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [3];
        for (int k = 0; k < 3; k++) begin
            rand_line(d[k]);
            drive_idle();
            refill_valid = 1'b1; refill_addr = AW'(k + 1); refill_data = d[k];
            @(negedge clk);
            model_eval();
            model_commit();
            next();
        end
        for (int k = 0; k < 5; k++) begin
            drive_idle();
            rd_valid = k < 3;
            rd_addr  = AW'(k + 1);
            @(negedge clk);
            model_eval();
            if (k < 3) begin
                checks++;
                if (rd_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready%0d got=%b exp=1", k, rd_ready);
                end
            end
            checks++;
            if (rd_rvalid !== (k >= 1 && k <= 3) || (k >= 1 && k <= 3 && rd_rdata !== d[k-1])) begin
                failures++;
                $display("FAIL b2b_resp%0d got v=%b d=%h", k, rd_rvalid, rd_rdata[127:0]);
            end
            model_commit();
            next();
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        for (int c = 0; c < 400; c++) begin
            refill_valid = $urandom_range(0, 3) != 0;
            refill_addr  = AW'($urandom_range(0, 7));
            rand_line(refill_data);
            st_valid = $urandom_range(0, 1) == 1;
            st_addr  = AW'($urandom_range(0, 7));
            rand_mask(st_wmask);
            rand_line(st_data);
            rd_valid = $urandom_range(0, 2) != 0;
            rd_addr  = AW'($urandom_range(0, 7));
            @(negedge clk);
            model_eval();
            exp_d = pend_m ? pend_d_m : last_m;
            checks++;
            if ({refill_valid && refill_ready, st_valid && st_ready, rd_valid && rd_ready} !== {e_ref, e_st, e_rd}) begin
                failures++;
                $display("FAIL rand_grant c=%0d got=%b exp=%b", c,
                         {refill_valid && refill_ready, st_valid && st_ready, rd_valid && rd_ready}, {e_ref, e_st, e_rd});
            end
            checks++;
            if ({sram_csb0, sram_csb1} !== {!(e_ref || e_st), !(e_rd && !e_byp)}) begin
                failures++;
                $display("FAIL rand_csb c=%0d got=%b exp=%b", c, {sram_csb0, sram_csb1}, {!(e_ref || e_st), !(e_rd && !e_byp)});
            end
            checks++;
            if (rd_rvalid !== pend_m || rd_rdata !== exp_d) begin
                failures++;
                $display("FAIL rand_resp c=%0d got v=%b d=%h exp v=%b d=%h", c, rd_rvalid, rd_rdata[127:0], pend_m, exp_d[127:0]);
            end
            model_commit();
            next();
        end
        drive_idle();
    endtask

    task automatic test_reset_in_run();
        drive_idle();
        rd_valid = 1'b1; rd_addr = 8'h01;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_run_acc got=%b exp=1", rd_ready);
        end
        next();
        rd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_rvalid, sram_csb0, sram_csb1, init_done} !== 4'b0110) begin
            failures++;
            $display("FAIL rst_run_drop got=%b exp=0110", {rd_rvalid, sram_csb0, sram_csb1, init_done});
        end
        next();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_rvalid, sram_csb0, sram_addr0, init_done} !== {2'b00, AW'(i), 1'b0}) begin
                failures++;
                $display("FAIL rst_run_sweep%0d got v=%b csb0=%b a=%h done=%b", i, rd_rvalid, sram_csb0, sram_addr0, init_done);
            end
            next();
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_starve();
        test_store_read();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
